// File: rtl/mem_access_seq_pkg.sv
// Shared encodings for the ALU -> ALUOut -> blockMemory16 -> memOut access sequencer.
package mem_access_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  // alu16b op select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_OVF   = 2'b01;
  localparam logic [1:0] FLT_RANGE = 2'b10;

endpackage

// File: rtl/mem_access_seq_addr_check.sv
// Combinational address legality check; also used by the stack-pointer bounds logic.
module mem_addr_check
  import mem_access_seq_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1024
) (
  input  logic [DATA_W-1:0] addr,
  input  logic              ovf,
  output logic              bad,
  output logic [1:0]        code
);

  logic range_bad;

  // Widen both sides so the compare is unsigned over the full address width.
  assign range_bad = 64'(addr) >= 64'(MEM_DEPTH);
  assign bad       = ovf || range_bad;
  assign code      = ovf ? FLT_OVF : (range_bad ? FLT_RANGE : FLT_NONE);

endmodule

// File: rtl/mem_access_seq.sv
// Moore sequencer stepping one load/store through address compute, memory access and writeback.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int DATA_W    = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req,
  input  logic              req_store,
  input  logic [1:0]        req_aluop,
  input  logic              alu_ovflw,
  input  logic [DATA_W-1:0] aluout_addr,
  output logic              ready,
  output logic [1:0]        alu_op,
  output logic              aluout_we,
  output logic              mem_wea,
  output logic              memout_we,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code
);

  state_t     state, state_nxt;
  logic [1:0] op_q;
  logic       store_q;
  logic       ovf_q;
  logic       bad;
  logic [1:0] chk_code;
  logic       accept;

  mem_addr_check #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_chk (
    .addr (aluout_addr),
    .ovf  (ovf_q),
    .bad  (bad),
    .code (chk_code)
  );

  assign accept = (state == S_IDLE) && req;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= ALU_ADD;
      store_q    <= 1'b0;
      ovf_q      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= req_aluop;
        store_q    <= req_store;
        fault_code <= FLT_NONE;
      end
      if (state == S_ADDR) ovf_q <= alu_ovflw;
      // Code lands as FAULT is entered so it is valid alongside the fault pulse.
      if (state == S_MEM && bad) fault_code <= chk_code;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_MEM;
      S_MEM: begin
        if (bad)          state_nxt = S_FAULT;
        else if (store_q) state_nxt = S_DONE;
        else              state_nxt = S_WB;
      end
      S_WB:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ready     = (state == S_IDLE);
  assign alu_op    = (state == S_IDLE) ? ALU_ADD : op_q;
  assign aluout_we = (state == S_ADDR);
  assign mem_wea   = (state == S_MEM) && store_q && !bad;
  assign memout_we = (state == S_WB);
  assign done      = (state == S_DONE);
  assign fault     = (state == S_FAULT);

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench: directed table, randomized transactions against a transaction-level model, corner sequences.
module tb_mem_access_seq;
  import mem_access_seq_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          CLK = 1'b0;
  logic          reset;
  logic          req, req_store, alu_ovflw;
  logic [1:0]    req_aluop;
  logic [DW-1:0] aluout_addr;
  logic          ready, aluout_we, mem_wea, memout_we, done, fault;
  logic [1:0]    alu_op, fault_code;

  mem_access_seq #(.MEM_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .CLK(CLK), .reset(reset), .req(req), .req_store(req_store), .req_aluop(req_aluop),
    .alu_ovflw(alu_ovflw), .aluout_addr(aluout_addr), .ready(ready), .alu_op(alu_op),
    .aluout_we(aluout_we), .mem_wea(mem_wea), .memout_we(memout_we), .done(done),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 CLK = ~CLK;

  // Datapath environment: blockMemory16 (registered read) and memOut register.
  logic [DW-1:0] bvalue, douta, memout;
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (mem_wea) mem[aluout_addr[9:0]] <= bvalue;
    douta <= mem[aluout_addr[9:0]];
    if (memout_we) memout <= douta;
  end

  // Reference model state: what memory should hold after each completed access.
  logic [DW-1:0] ref_mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit        store;
    bit [1:0]  aluop;
    bit [15:0] addr;
    bit        ovf;
    bit [15:0] data;
    bit [1:0]  exp_code;
    int        exp_lat;
    bit        exp_rd_chk;
    bit [15:0] exp_rd;
  } vec_t;

  // Drive one request, poke ignored req/op changes in ADDR, then compare everything observed.
  task automatic apply(input vec_t v, input string tag);
    int done_c, fault_c, wea, awe, awe_c, mowe, opbad, rdy, code1;
    logic [1:0]    code_end;
    logic [DW-1:0] rd;
    bit            fails;
    done_c = 0; fault_c = 0; wea = 0; awe = 0; awe_c = 0; mowe = 0;
    opbad = 0; rdy = 0; code1 = 3; code_end = 2'b11; rd = '0;
    fails = (v.exp_code != FLT_NONE);
    @(negedge CLK);
    check({tag, " ready_idle"}, 32'(ready), 1);
    req = 1'b1; req_store = v.store; req_aluop = v.aluop;
    aluout_addr = v.addr; bvalue = v.data; alu_ovflw = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        code1 = int'(fault_code);
        alu_ovflw = v.ovf;
        req_aluop = ~v.aluop;
        req_store = ~v.store;
      end else begin
        alu_ovflw = 1'b0;
        req = 1'b0;
      end
      if (ready) rdy++;
      if (aluout_we) begin awe++; awe_c = c; end
      if (mem_wea) wea++;
      if (memout_we) mowe++;
      if (alu_op !== v.aluop) opbad++;
      if (done && done_c == 0) begin done_c = c; code_end = fault_code; rd = memout; end
      if (fault && fault_c == 0) begin fault_c = c; code_end = fault_code; end
      if (done || fault) break;
    end
    req = 1'b0;
    check({tag, " latency"}, 32'(fails ? fault_c : done_c), 32'(v.exp_lat));
    check({tag, " fault_seen"}, 32'(fault_c != 0), 32'(fails));
    check({tag, " done_seen"}, 32'(done_c != 0), 32'(!fails));
    check({tag, " fault_code"}, 32'(code_end), 32'(v.exp_code));
    check({tag, " code_cleared"}, 32'(code1), 0);
    check({tag, " aluout_we"}, 32'({awe[7:0], awe_c[7:0]}), 32'h0101);
    check({tag, " mem_wea_cnt"}, 32'(wea), 32'(v.store && !fails));
    check({tag, " memout_we_cnt"}, 32'(mowe), 32'(!v.store && !fails));
    check({tag, " alu_op_stable"}, 32'(opbad), 0);
    check({tag, " ready_busy"}, 32'(rdy), 0);
    if (v.exp_rd_chk) check({tag, " load_data"}, 32'(rd), 32'(v.exp_rd));
    if (v.store && !fails) check({tag, " mem_word"}, 32'(mem[v.addr[9:0]]), 32'(v.data));
  endtask

  // Transaction-level model: outcome follows directly from the access rules.
  function automatic vec_t model(input bit store, input bit [1:0] op, input bit [15:0] addr,
                                 input bit ovf, input bit [15:0] data);
    vec_t v;
    v.store = store; v.aluop = op; v.addr = addr; v.ovf = ovf; v.data = data;
    v.exp_code   = ovf ? FLT_OVF : (int'(addr) >= DEPTH ? FLT_RANGE : FLT_NONE);
    v.exp_lat    = (v.exp_code != FLT_NONE) ? 3 : (store ? 3 : 4);
    v.exp_rd_chk = !store && v.exp_code == FLT_NONE;
    v.exp_rd     = v.exp_rd_chk ? ref_mem[addr[9:0]] : 16'h0;
    if (store && v.exp_code == FLT_NONE) ref_mem[addr[9:0]] = data;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, d1, d2, rdy5, wea_after;
    logic [DW-1:0] rd1, rd2;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    reset = 1'b1; req = 1'b0; req_store = 1'b0; req_aluop = ALU_ADD;
    alu_ovflw = 1'b0; aluout_addr = '0; bvalue = '0;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("reset ready", 32'(ready), 1);
    check("reset strobes", 32'({aluout_we, mem_wea, memout_we, done, fault}), 0);
    check("reset alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("reset fault_code", 32'(fault_code), 0);

    //           store aluop  addr     ovf  data     code       lat rdchk rd
    tbl[0] = '{1'b1, ALU_ADD, 16'h0010, 1'b0, 16'hBEEF, FLT_NONE,  3, 1'b0, 16'h0};
    tbl[1] = '{1'b0, ALU_ADD, 16'h0010, 1'b0, 16'h0000, FLT_NONE,  4, 1'b1, 16'hBEEF};
    tbl[2] = '{1'b1, ALU_ADD, 16'h0400, 1'b0, 16'h1111, FLT_RANGE, 3, 1'b0, 16'h0};
    tbl[3] = '{1'b1, ALU_SUB, 16'h03FF, 1'b0, 16'h1234, FLT_NONE,  3, 1'b0, 16'h0};
    tbl[4] = '{1'b0, ALU_OR,  16'h03FF, 1'b0, 16'h0000, FLT_NONE,  4, 1'b1, 16'h1234};
    tbl[5] = '{1'b1, ALU_ADD, 16'h0400, 1'b1, 16'h2222, FLT_OVF,   3, 1'b0, 16'h0};
    tbl[6] = '{1'b1, ALU_AND, 16'h0020, 1'b0, 16'h7777, FLT_NONE,  3, 1'b0, 16'h0};
    tbl[7] = '{1'b0, ALU_ADD, 16'h0010, 1'b1, 16'h0000, FLT_OVF,   3, 1'b0, 16'h0};
    tbl[8] = '{1'b0, ALU_SUB, 16'hFFFF, 1'b0, 16'h0000, FLT_RANGE, 3, 1'b0, 16'h0};
    ref_mem[16'h0010] = 16'hBEEF; ref_mem[16'h03FF] = 16'h1234; ref_mem[16'h0020] = 16'h7777;
    for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));
    check("range store left word", 32'(mem[0]), 0);

    for (int i = 0; i < 40; i++) begin
      bit [15:0] a;
      case ($urandom_range(0, 3))
        0: a = 16'($urandom_range(0, 15));
        1: a = 16'h03FF;
        2: a = 16'(DEPTH + $urandom_range(0, 200));
        default: a = 16'hFFFF - 16'($urandom_range(0, 50));
      endcase
      apply(model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                  $urandom_range(0, 4) == 0, 16'($urandom)), $sformatf("rnd%0d", i));
    end

    // Reset in the MEM cycle of a store must drop the write strobe with no clock edge.
    apply(model(1'b1, ALU_ADD, 16'h0030, 1'b0, 16'h5555), "pre_reset");
    @(negedge CLK);
    req = 1'b1; req_store = 1'b1; req_aluop = ALU_ADD; aluout_addr = 16'h0030; bvalue = 16'hAAAA;
    @(negedge CLK);
    req = 1'b0;
    @(negedge CLK);
    check("mid mem_wea before reset", 32'(mem_wea), 1);
    reset = 1'b1;
    #1;
    check("mid mem_wea after reset", 32'(mem_wea), 0);
    check("mid ready after reset", 32'(ready), 1);
    @(negedge CLK);
    reset = 1'b0;
    dn = 0; wea_after = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (done || fault) dn++;
      if (mem_wea) wea_after++;
    end
    check("mid no done", 32'(dn), 0);
    check("mid no write", 32'(wea_after), 0);
    check("mid word unchanged", 32'(mem[16'h0030]), 32'h5555);
    check("mid fault_code", 32'(fault_code), 0);

    // Held req: two loads, second accepted the cycle after DONE.
    @(negedge CLK);
    req = 1'b1; req_store = 1'b0; req_aluop = ALU_ADD; aluout_addr = 16'h0010;
    d1 = 0; d2 = 0; rdy5 = 0; rd1 = '0; rd2 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      if (k == 5) rdy5 = int'(ready);
      if (done) begin
        if (d1 == 0) begin d1 = k; rd1 = memout; end
        else if (d2 == 0) begin d2 = k; rd2 = memout; req = 1'b0; end
      end
    end
    req = 1'b0;
    check("b2b first done", 32'(d1), 4);
    check("b2b second done", 32'(d2), 9);
    check("b2b ready between", 32'(rdy5), 1);
    check("b2b data1", 32'(rd1), 32'(ref_mem[16'h0010]));
    check("b2b data2", 32'(rd2), 32'(ref_mem[16'h0010]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
